// File: rtl/mult_eval_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_eval_pkg
// Description : Shared types and constants for the multiplier evaluation
//               sequencer: FSM state encoding, LFSR polynomial and default
//               seed, and the single-step LFSR helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_eval_pkg;

    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // One step of a right-shifting Galois LFSR: the bit shifted out of the
    // bottom decides whether the polynomial taps are folded back in.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_eval_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : mult_eval_lfsr
// Description : 16-bit Galois LFSR operand source. A zero seed would lock the
//               register at zero, so it is replaced by DEFAULT_SEED.
// Ports       : clk      in   clock, rising edge
//               rst_n    in   asynchronous active-low reset (state <= seed)
//               i_load   in   reload the seed (has priority over i_step)
//               i_step   in   advance one LFSR step
//               o_state  out  current 16-bit LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module mult_eval_lfsr
    import mult_eval_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_step,
    output logic [15:0] o_state
);

    localparam logic [15:0] c_SEED = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= c_SEED;
        end else if (i_load) begin
            r_lfsr <= c_SEED;
        end else if (i_step) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_state = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/mult_eval_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mult_eval_sequencer
// Description : Stimulus/check controller for one combinational multiplier
//               candidate. Drives operand pairs (LFSR or exhaustive walk),
//               waits SETTLE cycles, compares P against the golden product,
//               counts mismatches and records the first failing vector.
// Ports       : clk        in   clock, rising edge
//               rst_n      in   asynchronous active-low reset
//               start      in   begin a run (honoured in IDLE/DONE only)
//               mult_a/b   out  registered operands to the multiplier
//               mult_p     in   product from the multiplier
//               busy       out  run in progress
//               done       out  run complete, held until next start
//               pass       out  done and no mismatches
//               err_count  out  saturating mismatch count
//               vec_count  out  vectors checked this run
//               fail_a/b/p out  operands and observed P of first mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module mult_eval_sequencer
    import mult_eval_pkg::*;
#(
    parameter int          WIDTH       = 2,
    parameter int          NUM_VECTORS = 20,
    parameter bit          EXHAUSTIVE  = 1'b0,
    parameter int          SETTLE      = 1,
    parameter logic [15:0] SEED        = DEFAULT_SEED,
    parameter int          ERR_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [WIDTH-1:0]       mult_a,
    output logic [WIDTH-1:0]       mult_b,
    input  logic [2*WIDTH-1:0]     mult_p,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_W-1:0]       err_count,
    output logic [2*WIDTH+15:0]    vec_count,
    output logic [WIDTH-1:0]       fail_a,
    output logic [WIDTH-1:0]       fail_b,
    output logic [2*WIDTH-1:0]     fail_p
);

    localparam int c_VC_W   = 2 * WIDTH + 16;
    localparam int c_WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_mult_a;
    logic [WIDTH-1:0]     r_mult_b;
    logic [c_WAIT_W-1:0]  r_wait;
    logic [ERR_W-1:0]     r_err_count;
    logic [c_VC_W-1:0]    r_vec_count;
    logic [WIDTH-1:0]     r_fail_a;
    logic [WIDTH-1:0]     r_fail_b;
    logic [2*WIDTH-1:0]   r_fail_p;

    logic                 w_reload;     // start accepted: clear results, rewind source
    logic                 w_load_ops;   // present next vector to the multiplier
    logic                 w_check;      // sample and judge the product
    logic                 w_src_last;   // vector under check is the final one
    logic [WIDTH-1:0]     w_src_a;
    logic [WIDTH-1:0]     w_src_b;
    logic [2*WIDTH-1:0]   w_golden;
    logic                 w_mismatch;

    // ------------------------------------------------------------------------
    // Operand source
    // ------------------------------------------------------------------------
    generate
        if (EXHAUSTIVE) begin : g_exhaustive
            // {A,B} is the counter itself, so A is the slow-moving half.
            logic [2*WIDTH-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_reload) begin
                    r_cnt <= '0;
                end else if (w_check) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_src_a    = r_cnt[2*WIDTH-1:WIDTH];
            assign w_src_b    = r_cnt[WIDTH-1:0];
            assign w_src_last = &r_cnt;
        end else begin : g_lfsr_src
            logic [15:0] w_lfsr;
            logic        w_unused_lfsr;

            mult_eval_lfsr #(
                .SEED    (SEED)
            ) u_lfsr (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_reload),
                .i_step  (w_check),
                .o_state (w_lfsr)
            );

            assign w_src_a       = w_lfsr[WIDTH-1:0];
            assign w_src_b       = w_lfsr[2*WIDTH-1:WIDTH];
            // Vector count has not yet been bumped for the vector in CHECK.
            assign w_src_last    = (r_vec_count == c_VC_W'(NUM_VECTORS - 1));
            // Only the low 2*WIDTH bits feed the operands.
            assign w_unused_lfsr = ^w_lfsr;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_reload     = 1'b0;
        w_load_ops   = 1'b0;
        w_check      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_reload     = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load_ops   = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait == '0) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_check      = 1'b1;
                w_state_next = w_src_last ? S_DONE : S_LOAD;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Golden compare. Case-inequality makes any X/Z on P a mismatch.
    // ------------------------------------------------------------------------
    assign w_golden   = {{WIDTH{1'b0}}, r_mult_a} * {{WIDTH{1'b0}}, r_mult_b};
    assign w_mismatch = (mult_p !== w_golden);

    // ------------------------------------------------------------------------
    // Operands, settle counter and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mult_a    <= '0;
            r_mult_b    <= '0;
            r_wait      <= '0;
            r_err_count <= '0;
            r_vec_count <= '0;
            r_fail_a    <= '0;
            r_fail_b    <= '0;
            r_fail_p    <= '0;
        end else begin
            if (w_reload) begin
                r_err_count <= '0;
                r_vec_count <= '0;
                r_fail_a    <= '0;
                r_fail_b    <= '0;
                r_fail_p    <= '0;
            end

            // WAIT lasts SETTLE cycles: it exits on the cycle the counter
            // reads zero, so it is preloaded with SETTLE-1.
            if (w_load_ops) begin
                r_mult_a <= w_src_a;
                r_mult_b <= w_src_b;
                r_wait   <= c_WAIT_W'(SETTLE - 1);
            end else if ((r_state == S_WAIT) && (r_wait != '0)) begin
                r_wait <= r_wait - 1'b1;
            end

            if (w_check) begin
                r_vec_count <= r_vec_count + 1'b1;
                if (w_mismatch) begin
                    // Counter saturates, so zero reliably means "no failure yet".
                    if (r_err_count == '0) begin
                        r_fail_a <= r_mult_a;
                        r_fail_b <= r_mult_b;
                        r_fail_p <= mult_p;
                    end
                    if (r_err_count != '1) begin
                        r_err_count <= r_err_count + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mult_a    = r_mult_a;
    assign mult_b    = r_mult_b;
    assign busy      = (r_state == S_LOAD) || (r_state == S_WAIT) || (r_state == S_CHECK);
    assign done      = (r_state == S_DONE);
    assign pass      = (r_state == S_DONE) && (r_err_count == '0);
    assign err_count = r_err_count;
    assign vec_count = r_vec_count;
    assign fail_a    = r_fail_a;
    assign fail_b    = r_fail_b;
    assign fail_p    = r_fail_p;

endmodule
`default_nettype wire

// File: tb/tb_mult_eval_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_eval_sequencer
// Description : Self-checking bench. Two sequencer instances: an exhaustive
//               WIDTH=2 one (small ERR_W so saturation is reachable) and an
//               LFSR WIDTH=3 one with a zero seed. Each drives a bench-side
//               multiplier with selectable fault behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_eval_sequencer;

    logic clk;
    logic rst_n;

    // Exhaustive instance
    logic        ex_start;
    logic [1:0]  ex_a, ex_b, ex_fa, ex_fb;
    logic [3:0]  ex_p, ex_fp;
    logic        ex_busy, ex_done, ex_pass;
    logic [2:0]  ex_err;
    logic [19:0] ex_vec;

    // LFSR instance
    logic        lf_start;
    logic [2:0]  lf_a, lf_b, lf_fa, lf_fb;
    logic [5:0]  lf_p, lf_fp;
    logic        lf_busy, lf_done, lf_pass;
    logic [15:0] lf_err;
    logic [21:0] lf_vec;

    // Bench multiplier behaviour
    int          ex_mode;
    logic [3:0]  ex_mask [16];
    logic [5:0]  lf_mask [64];

    int n_checks = 0;
    int n_errors = 0;

    // Expected operand sequences per instance: [0]=exhaustive, [1]=LFSR
    logic [31:0] exp_a [2][64];
    logic [31:0] exp_b [2][64];

    mult_eval_sequencer #(
        .WIDTH(2), .NUM_VECTORS(5), .EXHAUSTIVE(1'b1), .SETTLE(1),
        .SEED(16'hACE1), .ERR_W(3)
    ) u_dut_ex (
        .clk(clk), .rst_n(rst_n), .start(ex_start),
        .mult_a(ex_a), .mult_b(ex_b), .mult_p(ex_p),
        .busy(ex_busy), .done(ex_done), .pass(ex_pass),
        .err_count(ex_err), .vec_count(ex_vec),
        .fail_a(ex_fa), .fail_b(ex_fb), .fail_p(ex_fp)
    );

    mult_eval_sequencer #(
        .WIDTH(3), .NUM_VECTORS(20), .EXHAUSTIVE(1'b0), .SETTLE(2),
        .SEED(16'h0000), .ERR_W(16)
    ) u_dut_lf (
        .clk(clk), .rst_n(rst_n), .start(lf_start),
        .mult_a(lf_a), .mult_b(lf_b), .mult_p(lf_p),
        .busy(lf_busy), .done(lf_done), .pass(lf_pass),
        .err_count(lf_err), .vec_count(lf_vec),
        .fail_a(lf_fa), .fail_b(lf_fb), .fail_p(lf_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Candidate multipliers under test
    always_comb begin
        case (ex_mode)
            0:       ex_p = 4'(ex_a * ex_b);
            1:       ex_p = 4'(ex_a * ex_b) & 4'hE;     // P[0] stuck-0
            2:       ex_p = 4'h0;                       // P forced to zero
            3:       ex_p = 4'(ex_a * ex_b) | 4'h8;     // P[3] stuck-1
            default: ex_p = 4'(ex_a * ex_b) ^ ex_mask[{ex_a, ex_b}];
        endcase
    end
    assign lf_p = 6'(lf_a * lf_b) ^ lf_mask[{lf_a, lf_b}];

    typedef struct {
        logic [31:0] a, b, busy, done, pass, err, vec, fa, fb, fp;
    } obs_t;

    typedef struct {
        int          mode;
        int          pulse_at;
        logic [31:0] err, pass, fa, fb, fp;
        string       name;
    } vec_t;

    function automatic obs_t observe(input int s);
        obs_t o;
        if (s == 0) begin
            o.a = 32'(ex_a); o.b = 32'(ex_b); o.busy = 32'(ex_busy);
            o.done = 32'(ex_done); o.pass = 32'(ex_pass); o.err = 32'(ex_err);
            o.vec = 32'(ex_vec); o.fa = 32'(ex_fa); o.fb = 32'(ex_fb); o.fp = 32'(ex_fp);
        end else begin
            o.a = 32'(lf_a); o.b = 32'(lf_b); o.busy = 32'(lf_busy);
            o.done = 32'(lf_done); o.pass = 32'(lf_pass); o.err = 32'(lf_err);
            o.vec = 32'(lf_vec); o.fa = 32'(lf_fa); o.fb = 32'(lf_fb); o.fp = 32'(lf_fp);
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input int s, input string tag);
        obs_t o;
        o = observe(s);
        chk({tag, "_mult_a"}, o.a, 0);   chk({tag, "_mult_b"}, o.b, 0);
        chk({tag, "_busy"}, o.busy, 0);  chk({tag, "_done"}, o.done, 0);
        chk({tag, "_pass"}, o.pass, 0);  chk({tag, "_err"}, o.err, 0);
        chk({tag, "_vec"}, o.vec, 0);    chk({tag, "_fail_a"}, o.fa, 0);
        chk({tag, "_fail_b"}, o.fb, 0);  chk({tag, "_fail_p"}, o.fp, 0);
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 0) ex_start = v; else lf_start = v;
    endtask

    // Full run: start pulse, then cycle-exact checks of operand sequence,
    // done timing (n*per cycles after the start edge) and final results.
    task automatic run_check(input int s, input int n, input int per, input int pulse_at,
                             input string tag, input logic [31:0] e_err, input logic [31:0] e_pass,
                             input logic [31:0] e_fa, input logic [31:0] e_fb, input logic [31:0] e_fp);
        obs_t o;
        @(negedge clk); set_start(s, 1'b1);
        @(negedge clk); set_start(s, 1'b0);
        for (int c = 1; c <= n * per; c++) begin
            @(negedge clk);
            if (pulse_at != 0 && c == pulse_at)     set_start(s, 1'b1);
            if (pulse_at != 0 && c == pulse_at + 1) set_start(s, 1'b0);
            o = observe(s);
            if ((c - 1) % per == 0) begin
                chk($sformatf("%s op_a[%0d]", tag, (c - 1) / per), o.a, exp_a[s][(c - 1) / per]);
                chk($sformatf("%s op_b[%0d]", tag, (c - 1) / per), o.b, exp_b[s][(c - 1) / per]);
            end
            if (c == n * per - 1) begin
                chk({tag, " done_early"}, o.done, 0);
                chk({tag, " busy_before_done"}, o.busy, 1);
            end
        end
        o = observe(s);
        chk({tag, " done"}, o.done, 1);     chk({tag, " busy_end"}, o.busy, 0);
        chk({tag, " vec_count"}, o.vec, 32'(n));
        chk({tag, " err_count"}, o.err, e_err);
        chk({tag, " pass"}, o.pass, e_pass);
        chk({tag, " fail_a"}, o.fa, e_fa);
        chk({tag, " fail_b"}, o.fb, e_fb);
        chk({tag, " fail_p"}, o.fp, e_fp);
    endtask

    // Reference: walk the vector list, judge each against the true product.
    task automatic predict(input int s, input int n, input int sat,
                           output logic [31:0] e_err, output logic [31:0] e_pass,
                           output logic [31:0] e_fa, output logic [31:0] e_fb, output logic [31:0] e_fp);
        int errs = 0;
        e_fa = 0; e_fb = 0; e_fp = 0;
        for (int k = 0; k < n; k++) begin
            int a = int'(exp_a[s][k]);
            int b = int'(exp_b[s][k]);
            int m = (s == 0) ? int'(ex_mask[a * 4 + b]) : int'(lf_mask[a * 8 + b]);
            if (m != 0) begin
                if (errs == 0) begin
                    e_fa = 32'(a); e_fb = 32'(b); e_fp = 32'((a * b) ^ m);
                end
                errs++;
            end
        end
        e_err  = 32'((errs > sat) ? sat : errs);
        e_pass = 32'(errs == 0);
    endtask

    vec_t        tbl [5];
    logic [31:0] p_err, p_pass, p_fa, p_fb, p_fp;
    logic [15:0] s_lfsr;
    int          cyc;

    initial begin
        tbl[0] = '{0,  0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, "ex_ideal"};
        tbl[1] = '{1,  0, 32'd4, 32'd0, 32'd1, 32'd1, 32'd0, "ex_p0_stuck0"};
        tbl[2] = '{2,  0, 32'd7, 32'd0, 32'd1, 32'd1, 32'd0, "ex_p_zero_sat"};
        tbl[3] = '{3,  0, 32'd7, 32'd0, 32'd0, 32'd0, 32'd8, "ex_p3_stuck1"};
        tbl[4] = '{1, 20, 32'd4, 32'd0, 32'd1, 32'd1, 32'd0, "ex_start_busy"};

        // Exhaustive order: A major, B minor, from zero.
        for (int k = 0; k < 16; k++) begin
            exp_a[0][k] = 32'(k / 4);
            exp_b[0][k] = 32'(k % 4);
        end
        // LFSR order: zero seed becomes ACE1; A = low 3 bits, B = next 3.
        s_lfsr = 16'hACE1;
        for (int k = 0; k < 20; k++) begin
            exp_a[1][k] = 32'(s_lfsr % 8);
            exp_b[1][k] = 32'((s_lfsr / 8) % 8);
            s_lfsr = (s_lfsr % 2 == 1) ? ((s_lfsr / 2) ^ 16'hB400) : (s_lfsr / 2);
        end

        for (int i = 0; i < 16; i++) ex_mask[i] = 4'h0;
        for (int i = 0; i < 64; i++) lf_mask[i] = 6'h0;
        ex_mode  = 0;
        ex_start = 1'b0;
        lf_start = 1'b0;
        rst_n    = 1'b0;

        repeat (3) @(negedge clk);
        chk_zero(0, "reset_ex");
        chk_zero(1, "reset_lf");
        rst_n = 1'b1;

        // Directed fault table on the exhaustive instance
        for (int t = 0; t < 5; t++) begin
            ex_mode = tbl[t].mode;
            run_check(0, 16, 3, tbl[t].pulse_at, tbl[t].name,
                      tbl[t].err, tbl[t].pass, tbl[t].fa, tbl[t].fb, tbl[t].fp);
        end

        // start held high from DONE: immediate rerun with results cleared
        ex_mode = 0;
        @(negedge clk); ex_start = 1'b1;
        @(negedge clk);
        chk("rerun busy", 32'(ex_busy), 1);
        chk("rerun done_low", 32'(ex_done), 0);
        chk("rerun err_cleared", 32'(ex_err), 0);
        chk("rerun vec_cleared", 32'(ex_vec), 0);
        @(negedge clk); ex_start = 1'b0;
        cyc = 1;
        while (!ex_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rerun done_cycle", 32'(cyc), 48);
        chk("rerun pass", 32'(ex_pass), 1);

        // Reset asserted during WAIT of vector 5
        ex_mode = 3;
        @(negedge clk); ex_start = 1'b1;
        @(negedge clk); ex_start = 1'b0;
        repeat (13) @(negedge clk);
        chk("midrst err_before", 32'(ex_err), 4);
        chk("midrst busy_before", 32'(ex_busy), 1);
        rst_n = 1'b0;
        #1;
        chk_zero(0, "midrst_ex");
        @(negedge clk); rst_n = 1'b1;
        ex_mode = 0;
        run_check(0, 16, 3, 0, "after_reset", 0, 1, 0, 0, 0);

        // Random corruption tables, exhaustive instance
        ex_mode = 4;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++)
                ex_mask[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            predict(0, 16, 7, p_err, p_pass, p_fa, p_fb, p_fp);
            run_check(0, 16, 3, 0, $sformatf("ex_rand%0d", r), p_err, p_pass, p_fa, p_fb, p_fp);
        end

        // LFSR instance run twice: same operand sequence each time
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 64; i++)
                lf_mask[i] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'h0;
            predict(1, 20, 65535, p_err, p_pass, p_fa, p_fb, p_fp);
            run_check(1, 20, 4, 0, $sformatf("lf_run%0d", r), p_err, p_pass, p_fa, p_fb, p_fp);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
